// File: rtl/nios_mem_if_ddr2_emif_0_p0_flop_mem_ctrl.sv
// Round-robin, two-requester write queue controller for an external flop memory.
// It tracks the pointers, occupancy and status; the memory registers rd_data one edge after mem_rd_en.
module nios_mem_if_ddr2_emif_0_p0_flop_mem_ctrl #(
  parameter int MEM_DEPTH  = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  last_grant,
  output logic                  underflow_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  last_grant_q, last_grant_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  underflow_q, underflow_d;
  logic                  grant;
  logic                  wr_acc;
  logic                  pop_acc;

  // With no contention the grant still points at the requester that would win one.
  always_comb begin
    full  = (count_q == DEPTH_CNT);
    empty = (count_q == '0);
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
    else
      grant = !last_grant_q;
    req0_ready  = !full && !flush && !grant;
    req1_ready  = !full && !flush && grant;
    wr_acc      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    pop_acc     = pop && !empty && !flush;
    mem_wr_en   = wr_acc;
    mem_wr_addr = wr_ptr_q;
    mem_wr_data = grant ? req1_data : req0_data;
    mem_rd_en   = pop_acc;
    mem_rd_addr = rd_ptr_q;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    rd_valid_d   = pop_acc;
    underflow_d  = underflow_q || (pop && empty);
    if (wr_acc) begin
      wr_ptr_d     = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      last_grant_d = grant;
    end
    if (pop_acc)
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    if (wr_acc && !pop_acc)
      count_d = count_q + 1'b1;
    else if (pop_acc && !wr_acc)
      count_d = count_q - 1'b1;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rd_valid_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      underflow_q  <= underflow_d;
    end
  end

  assign count         = count_q;
  assign last_grant    = last_grant_q;
  assign rd_valid      = rd_valid_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_nios_mem_if_ddr2_emif_0_p0_flop_mem_ctrl.sv
// Directed bench for the flop-memory queue controller, with a small flop memory
// attached so popped data can be compared against the order it was written in.
module tb_nios_mem_if_ddr2_emif_0_p0_flop_mem_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       pop, flush;
  logic       mem_wr_en;
  logic [1:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       mem_rd_en;
  logic [1:0] mem_rd_addr;
  logic       rd_valid, full, empty;
  logic [2:0] count;
  logic       last_grant, underflow_err;

  logic [7:0] mem_model [4];
  logic [7:0] rd_data;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem_model[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) rd_data <= mem_model[mem_rd_addr];
  end

  nios_mem_if_ddr2_emif_0_p0_flop_mem_ctrl #(
    .MEM_DEPTH(4), .ADDR_WIDTH(2), .DATA_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .pop(pop), .flush(flush),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
    .last_grant(last_grant), .underflow_err(underflow_err)
  );

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    $display("test_reset");
    idle_inputs(); req0_data = 8'h00; req1_data = 8'h00;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow_err); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant got %b exp 1", last_grant); end
    checks++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got wr=%b rd=%b exp 0 0", mem_wr_en, mem_rd_en); end
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 10", req0_ready, req1_ready); end
    flush = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_flush_ready got %b%b exp 00", req0_ready, req1_ready); end
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    $display("test_round_robin");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h10; req1_data = 8'h20;
      #1;
      checks++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL rr_grant%0d got %b%b exp grant %0d", i, req0_ready, req1_ready, i % 2); end
      checks++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== i[1:0]) begin errors++; $display("FAIL rr_addr%0d got en=%b addr=%0d exp 1 %0d", i, mem_wr_en, mem_wr_addr, i); end
      checks++; if (mem_wr_data !== ((i % 2 == 0) ? 8'h10 : 8'h20)) begin errors++; $display("FAIL rr_data%0d got %h", i, mem_wr_data); end
      checks++; if (count !== 3'(i)) begin errors++; $display("FAIL rr_count%0d got %0d exp %0d", i, count, i); end
    end
    @(negedge clk);
    #1;
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL rr_full got full=%b count=%0d exp 1 4", full, count); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL rr_blocked got %b%b wr=%b exp 000", req0_ready, req1_ready, mem_wr_en); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL rr_last_grant got %b exp 1", last_grant); end
    idle_inputs();
  endtask

  task automatic test_full_pop();
    $display("test_full_pop");
    @(negedge clk);
    pop = 1'b1; req0_valid = 1'b1; req0_data = 8'h77;
    #1;
    checks++; if (req0_ready !== 1'b0 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL fp_write_blocked got ready=%b wr=%b exp 0 0", req0_ready, mem_wr_en); end
    checks++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 2'd0) begin errors++; $display("FAIL fp_read got en=%b addr=%0d exp 1 0", mem_rd_en, mem_rd_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fp_count got %0d exp 3", count); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h10) begin errors++; $display("FAIL fp_rd got valid=%b data=%h exp 1 10", rd_valid, rd_data); end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      pop = 1'b1;
      #1;
      checks++; if (mem_rd_addr !== k[1:0]) begin errors++; $display("FAIL fp_rd_addr%0d got %0d exp %0d", k, mem_rd_addr, k); end
      @(negedge clk);
      pop = 1'b0;
      #1;
      checks++; if (rd_valid !== 1'b1 || rd_data !== ((k % 2 == 0) ? 8'h10 : 8'h20)) begin errors++; $display("FAIL fp_drain%0d got valid=%b data=%h", k, rd_valid, rd_data); end
    end
    checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL fp_empty got empty=%b count=%0d exp 1 0", empty, count); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d;
    $display("test_wrap");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req1_valid = 1'b1; req1_data = 8'hA0 + 8'(i); pop = (i > 0);
      #1;
      checks++; if (req1_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_wr_addr !== i[1:0]) begin errors++; $display("FAIL wr_addr%0d got ready=%b en=%b addr=%0d exp 1 1 %0d", i, req1_ready, mem_wr_en, mem_wr_addr, i % 4); end
      checks++; if (count !== ((i == 0) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL wr_count%0d got %0d", i, count); end
      if (i > 0) begin
        checks++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 2'(i - 1)) begin errors++; $display("FAIL wr_rd_addr%0d got en=%b addr=%0d exp 1 %0d", i, mem_rd_en, mem_rd_addr, (i - 1) % 4); end
      end
      if (i >= 2) begin
        exp_d = 8'hA0 + 8'(i - 2);
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin errors++; $display("FAIL wr_order%0d got valid=%b data=%h exp 1 %h", i, rd_valid, rd_data, exp_d); end
      end
    end
    @(negedge clk);
    req1_valid = 1'b0; pop = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA4 || mem_rd_addr !== 2'd1) begin errors++; $display("FAIL wr_tail4 got valid=%b data=%h addr=%0d exp 1 a4 1", rd_valid, rd_data, mem_rd_addr); end
    @(negedge clk);
    pop = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin errors++; $display("FAIL wr_tail5 got valid=%b data=%h exp 1 a5", rd_valid, rd_data); end
    checks++; if (empty !== 1'b1 || count !== 3'd0 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL wr_final got empty=%b count=%0d wr=%b exp 1 0 0", empty, count, mem_wr_en); end
  endtask

  task automatic test_underflow_flush();
    $display("test_underflow_flush");
    @(negedge clk);
    pop = 1'b1; req1_valid = 1'b1; req1_data = 8'h5A;
    #1;
    checks++; if (mem_rd_en !== 1'b0 || req1_ready !== 1'b1 || mem_wr_data !== 8'h5A) begin errors++; $display("FAIL uf_same_cycle got rd=%b ready=%b data=%h exp 0 1 5a", mem_rd_en, req1_ready, mem_wr_data); end
    @(negedge clk);
    idle_inputs(); flush = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0 || underflow_err !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL uf_state got valid=%b err=%b count=%0d exp 0 1 1", rd_valid, underflow_err, count); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL uf_flush_ready got %b%b exp 00", req0_ready, req1_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || underflow_err !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL uf_flushed got count=%0d err=%b empty=%b exp 0 0 1", count, underflow_err, empty); end
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h61; req1_data = 8'h62;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || mem_wr_addr !== 2'd0 || mem_wr_data !== 8'h61) begin errors++; $display("FAIL uf_post_flush got %b%b addr=%0d data=%h exp 10 0 61", req0_ready, req1_ready, mem_wr_addr, mem_wr_data); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    $display("test_async_reset");
    req1_valid = 1'b1; req1_data = 8'h44;
    @(negedge clk);
    req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 8'h55; pop = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (count !== 3'd2 || rd_valid !== 1'b1 || rd_data !== 8'h61 || last_grant !== 1'b0) begin errors++; $display("FAIL ar_pre got count=%0d valid=%b data=%h lg=%b exp 2 1 61 0", count, rd_valid, rd_data, last_grant); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL ar_async got count=%0d empty=%b valid=%b exp 0 1 0", count, empty, rd_valid); end
    checks++; if (last_grant !== 1'b1 || full !== 1'b0 || mem_rd_addr !== 2'd0) begin errors++; $display("FAIL ar_state got lg=%b full=%b rd_addr=%0d exp 1 0 0", last_grant, full, mem_rd_addr); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pop = 1'b1;
    #1;
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL ar_no_residual got rd_en=%b exp 0", mem_rd_en); end
    @(negedge clk);
    pop = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || underflow_err !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL ar_underflow got valid=%b err=%b count=%0d exp 0 1 0", rd_valid, underflow_err, count); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full_pop();
    test_wrap();
    test_underflow_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_mem_if_ddr2_emif_0_p0_flop_mem_ctrl.md
NIOS_MEM_IF_DDR2_EMIF_0_P0_FLOP_MEM_CTRL -- requirements
Module: nios_mem_if_ddr2_emif_0_p0_flop_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4, number of flop-memory entries (2..2**ADDR_WIDTH, need not be a power of 2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, flop-memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, entry width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 req0_valid / req1_valid  in  1  write request, requester 0 / 1.
REQ-008 req0_data / req1_data  in  DATA_WIDTH  write payload.
REQ-009 req0_ready / req1_ready  out  1  write accepted this cycle when valid & ready.
REQ-010 pop  in  1  consumer read request.
REQ-011 flush  in  1  synchronous clear of queue state.
REQ-012 mem_wr_en, mem_wr_addr[ADDR_WIDTH-1:0], mem_wr_data[DATA_WIDTH-1:0]  out  flop-memory write port.
REQ-013 mem_rd_en, mem_rd_addr[ADDR_WIDTH-1:0]  out  flop-memory read port (memory registers rd_data one edge later).
REQ-014 rd_valid  out  1  flop-memory rd_data holds popped entry this cycle.
REQ-015 full, empty  out  1  queue status; count  out  ADDR_WIDTH+1  occupancy.
REQ-016 last_grant  out  1  requester of most recent accepted write.
REQ-017 underflow_err  out  1  sticky: pop seen while empty.

Function
REQ-018 Arbitration SHALL be round-robin: only one valid -> that one granted; both valid -> grant the requester not equal to last_grant.
REQ-019 reqN_ready SHALL be combinational = !full & !flush & (granted == N); at most one ready high per cycle.
REQ-020 Accepted write SHALL drive mem_wr_en=1, mem_wr_addr=wr_ptr, mem_wr_data=winning payload in the same cycle; mem_wr_en=0 otherwise.
REQ-021 last_grant SHALL update only on an accepted write.
REQ-022 Pop accepted SHALL be pop & !empty & !flush; mem_rd_en = pop accepted; mem_rd_addr = rd_ptr at all times.
REQ-023 rd_valid SHALL be registered: high exactly one cycle after each accepted pop (latency 1).
REQ-024 wr_ptr/rd_ptr SHALL increment on accept and wrap MEM_DEPTH-1 -> 0.
REQ-025 count: +1 on write only, -1 on pop only, unchanged on both; full = (count == MEM_DEPTH), empty = (count == 0), both combinational from count.
REQ-026 Write when full SHALL be blocked even if a pop is accepted the same cycle (full evaluated pre-edge).
REQ-027 Pop when empty SHALL be ignored even if a write is accepted the same cycle; underflow_err SHALL set.
REQ-028 Data written at edge k SHALL be poppable from cycle k+1 (no bypass).
REQ-029 flush SHALL, at the next edge, zero wr_ptr, rd_ptr, count, underflow_err and rd_valid; flush has priority over push and pop.

Reset
REQ-030 reset_n low SHALL asynchronously force wr_ptr=0, rd_ptr=0, count=0, last_grant=1 (first contention grants requester 0), rd_valid=0, underflow_err=0.
REQ-031 During reset outputs SHALL be: empty=1, full=0, both ready=0 only if flush is high, mem_wr_en=0, mem_rd_en=0.
REQ-032 Reset deassertion mid-operation SHALL leave no residual data visible; first pop after reset requires a prior write.

Verification (MEM_DEPTH=4, DATA_WIDTH=8)
REQ-033 Both requesters valid for 4 cycles, data 0x10/0x20 -> grants 0,1,0,1; mem_wr_addr 0,1,2,3; full=1, count=4, both ready=0 on cycle 5.
REQ-034 Queue full, pop and req0_valid same cycle -> write blocked, count=3 next cycle; rd_valid next cycle with rd_data=entry 0.
REQ-035 Six writes interleaved with pops -> wr_ptr wraps 3->0; popped data order matches write order exactly.
REQ-036 Empty queue, pop with simultaneous req1 write 0x5A -> no rd_valid, underflow_err=1, count=1; flush next cycle -> count=0, underflow_err=0.
REQ-037 Assert reset_n low mid-burst with count=2 -> count=0, empty=1, rd_valid=0 immediately, without a clock edge.
